// File: rtl/audio_pkg.sv
// Shared defaults for the audio decimator: phase step/modulus, DC-blocker leak
// shift, FIFO depth, and the phase-accumulator width helper.
package audio_pkg;

    localparam int DEF_MSB        = 15;
    localparam int DEF_STEP       = 960;
    localparam int DEF_MODULUS    = 71591;
    localparam int DEF_K          = 10;
    localparam int DEF_FIFO_DEPTH = 4;

    // Wide enough to hold acc+STEP before the wrap subtraction.
    function automatic int acc_width(input int modulus, input int step);
        return $clog2(modulus + step);
    endfunction

endpackage

// File: rtl/audio_fifo.sv
// Small output FIFO: push/full on the write side, valid/ready on the read side.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module audio_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = DEF_MSB + 1,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_full,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_wr_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    // Forced to zero when empty so stale storage never shows on the output.
    assign o_data  = o_valid ? r_mem[r_rd] : '0;
    assign w_pop   = o_valid & i_ready;
    assign w_wr_en = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr <= ptr_inc(r_wr);
            end
            if (w_pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/audio_decim.sv
// Fractional-phase audio decimator: captures one input sample per phase wrap,
// optionally removes DC with a leaky differentiator, and queues results.
module audio_decim
    import audio_pkg::*;
#(
    parameter int MSB     = DEF_MSB,
    parameter int STEP    = DEF_STEP,
    parameter int MODULUS = DEF_MODULUS,
    parameter int K       = DEF_K
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         CE,
    input  logic         DC_EN,
    input  logic [MSB:0] IDATA,
    output logic [MSB:0] O_DATA,
    output logic         O_VALID,
    input  logic         O_READY,
    output logic         OVF,
    input  logic         OVF_CLR
);

    localparam int AW    = acc_width(MODULUS, STEP);
    localparam int DW    = MSB + K + 2;
    localparam int DEPTH = DEF_FIFO_DEPTH;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [AW:0]          STEP_V = (AW+1)'(STEP);
    localparam logic [AW:0]          MOD_V  = (AW+1)'(MODULUS);
    localparam logic [MSB:0]         MID    = {1'b1, {MSB{1'b0}}};
    localparam logic [MSB:0]         POS_FS = {1'b0, {MSB{1'b1}}};
    localparam logic signed [DW-1:0] SAT_HI = {{(K+2){1'b0}}, {MSB{1'b1}}};
    localparam logic signed [DW-1:0] SAT_LO = {{(K+2){1'b1}}, {MSB{1'b0}}};

    logic [AW-1:0]          r_acc;
    logic [MSB:0]           r_cap;
    logic                   r_cap_vld;
    logic signed [MSB:0]    r_xprev;
    logic signed [DW-1:0]   r_yprev;
    logic                   r_ovf;

    logic [AW:0]            w_acc_sum;
    logic                   w_wrap;
    logic signed [MSB:0]    w_x;
    logic signed [DW-1:0]   w_x_ext;
    logic signed [DW-1:0]   w_xp_ext;
    logic signed [DW-1:0]   w_dx;
    logic signed [DW-1:0]   w_y_full;
    logic signed [DW-1:0]   w_y_out;
    logic [MSB:0]           w_dc;
    logic [MSB:0]           w_result;
    logic                   w_fifo_full;
    logic [CW-1:0]          w_fifo_count;
    logic                   w_pop;
    logic                   w_drop;

    assign w_acc_sum = {1'b0, r_acc} + STEP_V;
    assign w_wrap    = CE & (w_acc_sum >= MOD_V);

    assign w_x      = signed'(r_cap ^ MID);
    assign w_x_ext  = DW'(w_x);
    assign w_xp_ext = DW'(r_xprev);
    assign w_dx     = w_x_ext - w_xp_ext;
    // y is held with K fraction bits so the leak keeps decaying below one LSB.
    assign w_y_full = (w_dx <<< K) + r_yprev - (r_yprev >>> K);
    assign w_y_out  = w_y_full >>> K;

    always_comb begin
        w_dc = w_y_out[MSB:0];
        if (w_y_out > SAT_HI) begin
            w_dc = POS_FS;
        end else if (w_y_out < SAT_LO) begin
            w_dc = MID;
        end
    end

    assign w_result = DC_EN ? w_dc : (r_cap ^ MID);
    assign w_pop    = O_READY & (w_fifo_count != '0);
    assign w_drop   = r_cap_vld & w_fifo_full & ~w_pop;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_acc     <= '0;
            r_cap     <= '0;
            r_cap_vld <= 1'b0;
            r_xprev   <= '0;
            r_yprev   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (CE) begin
                r_acc <= w_wrap ? AW'(w_acc_sum - MOD_V) : AW'(w_acc_sum);
            end
            r_cap_vld <= w_wrap;
            if (w_wrap) begin
                r_cap <= IDATA;
            end
            if (r_cap_vld) begin
                if (DC_EN) begin
                    r_xprev <= w_x;
                    r_yprev <= w_y_full;
                end else begin
                    r_xprev <= '0;
                    r_yprev <= '0;
                end
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (OVF_CLR) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign OVF = r_ovf;

    audio_fifo #(
        .WIDTH (MSB + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_push  (r_cap_vld),
        .i_data  (w_result),
        .o_full  (w_fifo_full),
        .o_data  (O_DATA),
        .o_valid (O_VALID),
        .i_ready (O_READY),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_audio_decim.sv
// Randomised bench for audio_decim against a sample-level reference model.
module tb_audio_decim;

    localparam longint STEP    = 960;
    localparam longint MODULUS = 71591;
    localparam int     K       = 10;
    localparam int     DEPTH   = 4;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CE;
    logic        DC_EN;
    logic [15:0] IDATA;
    logic [15:0] O_DATA;
    logic        O_VALID;
    logic        O_READY;
    logic        OVF;
    logic        OVF_CLR;

    audio_decim dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .CE      (CE),
        .DC_EN   (DC_EN),
        .IDATA   (IDATA),
        .O_DATA  (O_DATA),
        .O_VALID (O_VALID),
        .O_READY (O_READY),
        .OVF     (OVF),
        .OVF_CLR (OVF_CLR)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_err    = 0;
    longint      ce_count;
    bit          pend_vld;
    logic [15:0] pend_data;
    longint      m_xp;
    longint      m_yp;
    logic [15:0] q[$];
    bit          m_ovf;
    int          n_push    = 0;
    int          dut_pops  = 0;
    logic [15:0] dut_last  = 16'h0;
    bit          s3_on     = 1'b0;
    logic [15:0] s3_prev   = 16'h0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // k-th CE since reset produces a sample when floor(k*STEP/MODULUS) steps up.
    function automatic bit wraps_on(input longint k);
        return ((k * STEP) / MODULUS) != (((k - 1) * STEP) / MODULUS);
    endfunction

    function automatic logic [15:0] dc_model(input logic [15:0] d, input bit en);
        longint x, yf, y;
        x = longint'(d) - 32768;
        if (!en) begin
            m_xp = 0;
            m_yp = 0;
            return x[15:0];
        end
        yf = (x - m_xp) * (longint'(1) << K) + m_yp - (m_yp >>> K);
        y  = yf >>> K;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        m_xp = x;
        m_yp = yf;
        return y[15:0];
    endfunction

    task automatic step(input bit ce, input logic [15:0] d, input bit rdy, input bit clr, input bit en);
        bit          drop;
        logic [15:0] v;
        if (O_VALID && rdy) begin
            dut_pops++;
            if (s3_on) begin
                check_val("s3_mono", (signed'(O_DATA) <= signed'(s3_prev)) && !O_DATA[15], 1);
                s3_prev = O_DATA;
            end
            dut_last = O_DATA;
        end
        CE = ce; IDATA = d; O_READY = rdy; OVF_CLR = clr; DC_EN = en;
        drop = 1'b0;
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (pend_vld) begin
            v = dc_model(pend_data, en);
            n_push++;
            if (q.size() < DEPTH) q.push_back(v);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (ce) begin
            ce_count++;
            pend_vld  = wraps_on(ce_count);
            pend_data = d;
        end else begin
            pend_vld = 1'b0;
        end
        @(posedge CLK);
        @(negedge CLK);
        check_val("o_valid", O_VALID, q.size() > 0);
        if (q.size() > 0) check_val("o_data", O_DATA, q[0]);
        check_val("ovf", OVF, m_ovf);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0; CE = 1'b0; O_READY = 1'b0; OVF_CLR = 1'b0;
        #1;
        check_val("rst_valid", O_VALID, 0);
        check_val("rst_data", O_DATA, 0);
        check_val("rst_ovf", OVF, 0);
        q.delete();
        pend_vld = 1'b0; ce_count = 0; m_xp = 0; m_yp = 0; m_ovf = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic run_pushes(input int n, input logic [15:0] d, input bit rnd, input bit rdy, input bit en);
        int target, guard;
        target = n_push + n;
        guard  = 0;
        while (n_push < target && guard < 2000 * n) begin
            step(1'b1, rnd ? 16'($urandom) : d, rdy, 1'b0, en);
            guard++;
        end
        check_val("push_budget", n_push >= target, 1);
    endtask

    task automatic drain(input bit en);
        int g;
        g = 0;
        while ((q.size() > 0 || pend_vld) && g < 20) begin
            step(1'b0, 16'h8000, 1'b1, 1'b0, en);
            g++;
        end
        step(1'b0, 16'h8000, 1'b1, 1'b0, en);
    endtask

    initial begin
        int  p, g;
        bit  en, rdy, ce, clr;
        RESET_N = 1'b0; CE = 1'b0; DC_EN = 1'b0; IDATA = 16'h0; O_READY = 1'b0; OVF_CLR = 1'b0;
        @(negedge CLK);
        do_reset();

        // CE every cycle from reset: sample count follows STEP/MODULUS exactly
        p = dut_pops;
        for (int i = 0; i < 20000; i++)
            step(1'b1, 16'($urandom_range(16'h1000, 16'hEFFF)), 1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);
        check_val("s1_count", dut_pops - p, int'((20000 * STEP) / MODULUS));
        check_val("s1_ovf", OVF, 0);

        // Bypass: midscale -> 0, full scale -> 7FFF
        for (int i = 0; i < 300; i++) step(1'b1, 16'h8000, 1'b1, 1'b0, 1'b0);
        drain(1'b0);
        check_val("s2_mid", dut_last, 16'h0000);
        for (int i = 0; i < 300; i++) step(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        drain(1'b0);
        check_val("s2_fs", dut_last, 16'h7FFF);

        // DC blocker negative saturation on a full-swing fall
        run_pushes(1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        run_pushes(1, 16'h0000, 1'b0, 1'b1, 1'b1);
        drain(1'b1);
        check_val("sat_neg", dut_last, 16'h8000);

        // Step response 8000 -> C000
        run_pushes(1, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_pushes(1, 16'h8000, 1'b0, 1'b1, 1'b1);
        run_pushes(1, 16'hC000, 1'b0, 1'b1, 1'b1);
        drain(1'b1);
        check_val("s3_first", dut_last, 16'h4000);
        s3_on = 1'b1; s3_prev = dut_last;
        run_pushes(100, 16'hC000, 1'b0, 1'b1, 1'b1);
        drain(1'b1);
        s3_on = 1'b0;
        check_val("s3_decay", (dut_last > 16'h3800) && (dut_last < 16'h3C00), 1);

        // Backpressure for 6 wraps, then clear and drain
        step(1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
        run_pushes(4, 16'h0, 1'b1, 1'b0, 1'b0);
        check_val("s4_ovf_4", OVF, 0);
        run_pushes(1, 16'h0, 1'b1, 1'b0, 1'b0);
        check_val("s4_ovf_5", OVF, 1);
        run_pushes(1, 16'h0, 1'b1, 1'b0, 1'b0);
        check_val("s4_valid", O_VALID, 1);
        p = dut_pops;
        step(1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
        check_val("s4_clr", OVF, 0);
        drain(1'b0);
        check_val("s4_count", dut_pops - p, 4);

        // Full FIFO with push and pop on the same edge
        p = dut_pops;
        run_pushes(4, 16'h0, 1'b1, 1'b0, 1'b0);
        g = 0;
        while (!pend_vld && g < 2000) begin
            step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
            g++;
        end
        check_val("s5_budget", pend_vld, 1);
        step(1'b0, 16'h8000, 1'b1, 1'b0, 1'b0);
        check_val("s5_ovf", OVF, 0);
        check_val("s5_valid", O_VALID, 1);
        drain(1'b0);
        check_val("s5_count", dut_pops - p, 5);

        // Reset with samples queued, then first-wrap latency
        run_pushes(3, 16'h0, 1'b1, 1'b0, 1'b0);
        check_val("s6_q3", O_VALID, 1);
        do_reset();
        for (int i = 0; i < 74; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        check_val("s6_pre", O_VALID, 0);
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        check_val("s6_75", O_VALID, 0);
        step(1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);
        check_val("s6_76", O_VALID, 1);
        check_val("s6_data", O_DATA, 16'h9234);
        drain(1'b0);

        // Random traffic with periodic backpressure windows
        en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            rdy = ((i % 2000) < 600) ? 1'b0 : ($urandom_range(0, 99) < 60);
            ce  = ($urandom_range(0, 99) < 70);
            clr = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 999) == 0) en = ~en;
            step(ce, 16'($urandom_range(16'h1000, 16'hEFFF)), rdy, clr, en);
        end
        drain(en);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_decim.md
AUDIO_DECIM -- requirements
Module: audio_decim

Interface
REQ-001 SHALL have parameter MSB, default 15; sample MSB index, so the data width is MSB+1.
REQ-002 SHALL have parameter STEP, default 960; phase increment applied per CE.
REQ-003 SHALL have parameter MODULUS, default 71591; phase wrap value (3.579545 MHz * 960/71591 = 48.000 kHz).
REQ-004 SHALL have parameter K, default 10; DC-blocker leak shift.
REQ-005 SHALL have port CLK, input, 1 bit; the single clock.
REQ-006 SHALL have port RESET_N, input, 1 bit; reset, asynchronous, active-low.
REQ-007 SHALL have port CE, input, 1 bit; input-sample enable at the upstream low-pass filter rate.
REQ-008 SHALL have port DC_EN, input, 1 bit; 1 enables the DC blocker, 0 bypasses it.
REQ-009 SHALL have port IDATA, input, MSB+1 bits; unsigned filtered sample from the upstream low-pass filter.
REQ-010 SHALL have port O_DATA, output, MSB+1 bits; signed two's-complement output sample.
REQ-011 SHALL have port O_VALID, output, 1 bit; high when O_DATA holds a sample.
REQ-012 SHALL have port O_READY, input, 1 bit; consumer accepts the sample.
REQ-013 SHALL have port OVF, output, 1 bit; sticky flag, set when a sample is dropped.
REQ-014 SHALL have port OVF_CLR, input, 1 bit; synchronous clear of OVF.

Function
REQ-015 SHALL keep a phase accumulator of ceil(log2(MODULUS+STEP)) bits, 17 at default parameters.
REQ-016 On a cycle with CE=1, SHALL do acc <= acc+STEP-MODULUS if acc+STEP >= MODULUS, else acc <= acc+STEP; acc SHALL hold when CE=0.
REQ-017 A wrap in cycle N SHALL capture IDATA into the capture register at edge N; no capture otherwise.
REQ-018 Signed conversion SHALL be x = IDATA XOR 2^MSB, i.e. subtract the midscale offset.
REQ-019 At edge N+1, with DC_EN=1, SHALL compute y = x - x_prev + y_prev - (y_prev >>> K) at MSB+K+2 bits internally.
REQ-020 The DC-blocker result SHALL saturate to [-2^MSB, 2^MSB-1].
REQ-021 SHALL update x_prev and y_prev only on captured samples; y_prev SHALL hold the unsaturated full-precision value.
REQ-022 With DC_EN=0, the edge N+1 result SHALL be x; x_prev and y_prev SHALL clear to 0 so that re-enable starts clean.
REQ-023 At edge N+1, SHALL push the result into a 4-entry FIFO; O_VALID SHALL be high from edge N+1 when the FIFO was empty, giving 2-edge latency from the wrap CE.
REQ-024 Handshake: a pop SHALL occur on any edge where O_VALID=1 and O_READY=1; O_DATA SHALL be the FIFO head and stay stable while O_VALID=1 and O_READY=0.
REQ-025 Push while full and no simultaneous pop: SHALL drop the new sample, keep the FIFO contents, and set OVF.
REQ-026 Simultaneous push and pop when full: SHALL accept the push, with no drop and count unchanged.
REQ-027 Simultaneous push and pop when empty: the push SHALL land and O_VALID SHALL rise; there is no pop, since O_VALID was 0.
REQ-028 Simultaneous OVF_CLR and a drop: set SHALL win.
REQ-029 A CE gap or a deasserted CE SHALL never create or drop samples; the output rate SHALL be exactly STEP/MODULUS x CE rate over the long term.

Reset
REQ-030 RESET_N=0 SHALL immediately clear acc, the capture register, x_prev, y_prev, FIFO pointers and count, and OVF; O_VALID SHALL be 0 and O_DATA SHALL be 0.
REQ-031 Reset mid-operation SHALL discard the in-flight sample and all FIFO contents.
REQ-032 The first wrap after release SHALL occur on the ceil(MODULUS/STEP)-th CE, which is the 75th at default parameters.

Structure
REQ-033 A shared package audio_pkg SHALL hold the default STEP, MODULUS, and K constants and a function computing the accumulator width.
REQ-034 The FIFO SHALL be the sub-module audio_fifo, parameterised by width and depth (default 4), with valid/ready on its output, push/full on its input, and count; the module SHALL contain nothing else.

Verification
REQ-035 Scenario 1: CE every cycle, 1,000,000 CEs, O_READY=1 -> exactly 13409 or 13410 samples (1,000,000 x 960/71591 = 13409.5), OVF=0.
REQ-036 Scenario 2: DC_EN=0, IDATA=16'h8000 constant -> every O_DATA=0; IDATA=16'hFFFF -> O_DATA=16'h7FFF.
REQ-037 Scenario 3: DC_EN=1, IDATA step from 16'h8000 to 16'hC000 -> first output 16'h4000, decaying monotonically toward 0, below 16'h0100 within 6000 samples.
REQ-038 Scenario 4: O_READY=0 for 6 wraps -> 4 samples held in order, OVF=1 after the 5th wrap; then OVF_CLR with O_READY=1 -> the 4 oldest samples are delivered and OVF=0.
REQ-039 Scenario 5: FIFO full, with the push and the pop on the same edge -> no drop, OVF stays 0, order preserved.
REQ-040 Scenario 6: RESET_N pulsed low while 3 samples are queued -> O_VALID=0 immediately; after release the first output arrives 2 edges after the 75th CE.
